// File: rtl/uart_pkg.sv
// uart_pkg: shared types and defaults for the UART receive front-end.
//   rx_state_t            receiver FSM state encoding
//   DEFAULT_CLKS_PER_BIT  clk cycles per UART bit (100 MHz / 115200)
//   DEFAULT_FIFO_DEPTH    receive FIFO entries
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    BRKWAIT = 3'd4
  } rx_state_t;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;
  localparam int unsigned DEFAULT_FIFO_DEPTH   = 16;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: consumer-side bundle of the UART receive front-end.
//   rx_pop     consumer takes the head byte this cycle
//   err_clr    clears the sticky error flags
//   rxdata     head byte, 8'h00 when empty
//   rx_valid   FIFO non-empty
//   rx_full    FIFO holds its full depth
//   overrun    sticky: a received byte was dropped on a full FIFO
//   frame_err  sticky: a stop bit was sampled low
// Handshake: rxdata is valid whenever rx_valid is high; a byte is consumed on
// every rising edge where rx_valid && rx_pop. rx_pop with rx_valid low is
// ignored. There is no back-pressure towards the serial line.
interface uart_rx_fifo_if;
  logic       rx_pop;
  logic       err_clr;
  logic [7:0] rxdata;
  logic       rx_valid;
  logic       rx_full;
  logic       overrun;
  logic       frame_err;

  modport master (
    input  rx_pop, err_clr,
    output rxdata, rx_valid, rx_full, overrun, frame_err
  );

  modport slave (
    output rx_pop, err_clr,
    input  rxdata, rx_valid, rx_full, overrun, frame_err
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with synchronous active-high reset.
//   clk, rst   clock and synchronous reset
//   push, din  write request and data
//   pop        read request (head advances on the edge)
//   dout       head entry, zero when empty
//   empty/full occupancy flags; count = number of entries
//   push_drop  push refused because the FIFO is full and not popping
// A push on a full FIFO is accepted only when a pop frees the slot in the same
// cycle. A pop on an empty FIFO is ignored, even alongside a push.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             push_drop
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [CW-1:0]    cnt;
  logic             do_push, do_pop;

  assign empty     = (cnt == '0);
  assign full      = (cnt == CW'(DEPTH));
  assign count     = cnt;
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || pop);
  assign push_drop = push && full && !pop;
  assign dout      = empty ? '0 : mem[rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through FIFO.
//   clk, rst    system clock, synchronous active-high reset
//   rxd         asynchronous serial line, idle high
//   bus         consumer bundle (rx_pop, err_clr, rxdata, rx_valid, rx_full,
//               overrun, frame_err)
//   dbg_state   current receiver FSM state
//   dbg_count   current FIFO occupancy
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rxd,
  uart_rx_fifo_if.master              bus,
  output rx_state_t                   dbg_state,
  output logic [$clog2(FIFO_DEPTH):0] dbg_count
);

  localparam int BCW = $clog2(CLKS_PER_BIT);
  localparam logic [BCW-1:0] BC_HALF = BCW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(CLKS_PER_BIT - 1);

  rx_state_t      state, state_n;
  logic           rx_meta, rxs;
  logic [BCW-1:0] bc, bc_n;
  logic [2:0]     idx, idx_n;
  logic [7:0]     shift, shift_n;
  logic           push_pend, push_n;
  logic           ferr_set;
  logic           fifo_drop, fifo_empty, fifo_full;

  // Two-flop synchroniser; resets to the idle line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bc        <= '0;
      idx       <= '0;
      shift     <= '0;
      push_pend <= 1'b0;
    end else begin
      state     <= state_n;
      bc        <= bc_n;
      idx       <= idx_n;
      shift     <= shift_n;
      push_pend <= push_n;
    end
  end

  always_comb begin
    state_n  = state;
    bc_n     = bc + BCW'(1);
    idx_n    = idx;
    shift_n  = shift;
    push_n   = 1'b0;
    ferr_set = 1'b0;
    case (state)
      IDLE: begin
        bc_n = '0;
        if (!rxs) state_n = START;
      end
      START: begin
        // Mid start bit: a high line here means the falling edge was a glitch.
        if (bc == BC_HALF) begin
          bc_n  = '0;
          idx_n = '0;
          state_n = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bc == BC_LAST) begin
          bc_n         = '0;
          shift_n[idx] = rxs;
          if (idx == 3'd7) state_n = STOP;
          else             idx_n   = idx + 3'd1;
        end
      end
      STOP: begin
        if (bc == BC_LAST) begin
          bc_n = '0;
          if (rxs) begin
            push_n  = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_n  = BRKWAIT;
          end
        end
      end
      BRKWAIT: begin
        // Hold off until the line returns high so a break cannot start frames.
        bc_n = '0;
        if (rxs) state_n = IDLE;
      end
      default: begin
        bc_n    = '0;
        state_n = IDLE;
      end
    endcase
  end

  // shift stays stable through the push cycle: DATA cannot be re-entered
  // within one cycle of leaving STOP.
  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_pend),
    .pop       (bus.rx_pop),
    .din       (shift),
    .dout      (bus.rxdata),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (dbg_count),
    .push_drop (fifo_drop)
  );

  // A set event in the same cycle as err_clr keeps the flag high.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.overrun   <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      bus.overrun   <= fifo_drop | (bus.overrun & ~bus.err_clr);
      bus.frame_err <= ferr_set  | (bus.frame_err & ~bus.err_clr);
    end
  end

  assign bus.rx_valid = !fifo_empty;
  assign bus.rx_full  = fifo_full;
  assign dbg_state    = state;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: self-checking bench for uart_rx_fifo with CLKS_PER_BIT=8
// and FIFO_DEPTH=4. A queue holds the bytes the receiver should be buffering;
// two bits hold the expected sticky flags.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic      clk = 1'b0;
  logic      rst;
  logic      rxd;
  rx_state_t dbg_state;
  logic [2:0] dbg_count;

  uart_rx_fifo_if u_if ();

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .bus       (u_if),
    .dbg_state (dbg_state),
    .dbg_count (dbg_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic       exp_overrun = 1'b0;
  logic       exp_ferr    = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Driver: one 8N1 frame, LSB first; a bad stop bit is stretched by brk cycles.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int brk);
    rxd = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(CPB);
    end
    rxd = stop_ok;
    idle(CPB);
    if (!stop_ok) idle(brk);
    rxd = 1'b1;
    idle(12);
  endtask

  // Reference: what one completed frame does to the buffered bytes and flags.
  task automatic model_frame(input logic [7:0] b, input logic stop_ok);
    if (!stop_ok)                  exp_ferr = 1'b1;
    else if (exp_q.size() == DEPTH) exp_overrun = 1'b1;
    else                           exp_q.push_back(b);
  endtask

  task automatic check_all(input string tag);
    logic [7:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
    check({tag, "_valid"},  {31'd0, u_if.rx_valid},  {31'd0, exp_q.size() != 0});
    check({tag, "_rxdata"}, {24'd0, u_if.rxdata},    {24'd0, head});
    check({tag, "_full"},   {31'd0, u_if.rx_full},   {31'd0, exp_q.size() == DEPTH});
    check({tag, "_count"},  {29'd0, dbg_count},      32'(exp_q.size()));
    check({tag, "_ovr"},    {31'd0, u_if.overrun},   {31'd0, exp_overrun});
    check({tag, "_ferr"},   {31'd0, u_if.frame_err}, {31'd0, exp_ferr});
  endtask

  task automatic pop_byte();
    u_if.rx_pop = 1'b1;
    @(negedge clk);
    u_if.rx_pop = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic pop_check(input string tag);
    check({tag, "_head"}, {24'd0, u_if.rxdata}, {24'd0, (exp_q.size() != 0) ? exp_q[0] : 8'h00});
    pop_byte();
  endtask

  task automatic err_clear();
    u_if.err_clr = 1'b1;
    @(negedge clk);
    u_if.err_clr = 1'b0;
    exp_overrun = 1'b0;
    exp_ferr    = 1'b0;
  endtask

  initial begin
    int n;
    logic [7:0] b;
    logic ok;

    rst = 1'b1;
    rxd = 1'b1;
    u_if.rx_pop  = 1'b0;
    u_if.err_clr = 1'b0;
    idle(4);
    check_all("reset");
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    idle(4);

    // 1: single frame, then pop
    send_frame(8'hA5, 1'b1, 0);
    model_frame(8'hA5, 1'b1);
    check_all("t1_rx");
    pop_byte();
    check_all("t1_pop");

    // 2: short glitch is not a start bit
    rxd = 1'b0;
    idle(2);
    rxd = 1'b1;
    idle(20);
    check("t2_state", 32'(dbg_state), 32'(IDLE));
    check_all("t2");

    // 3: five frames into a depth-4 FIFO
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 0);
      model_frame(8'(i), 1'b1);
    end
    check_all("t3_full");
    for (int i = 0; i < 4; i++) pop_check("t3_drain");
    check_all("t3_empty");
    err_clear();
    check_all("t3_clr");

    // 4: bad stop bit held low as a break, then a clean frame
    send_frame(8'h3C, 1'b0, 40);
    model_frame(8'h3C, 1'b0);
    check_all("t4_break");
    send_frame(8'h7E, 1'b1, 0);
    model_frame(8'h7E, 1'b1);
    check_all("t4_rx");
    err_clear();
    check_all("t4_clr");
    pop_check("t4_pop");

    // 5: pop coincides with the push that arrives on a full FIFO
    for (int i = 0; i < 4; i++) begin
      send_frame(8'h11 + 8'(i), 1'b1, 0);
      model_frame(8'h11 + 8'(i), 1'b1);
    end
    check_all("t5_full");
    fork
      send_frame(8'h55, 1'b1, 0);
      begin
        n = 0;
        while (dbg_state != STOP && n < 300) begin
          @(negedge clk);
          n++;
        end
        check("t5_reach_stop", 32'(dbg_state), 32'(STOP));
        n = 0;
        while (dbg_state == STOP && n < 40) begin
          @(negedge clk);
          n++;
        end
        u_if.rx_pop = 1'b1;
        @(negedge clk);
        u_if.rx_pop = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(8'h55);
      end
    join
    check_all("t5_simul");
    for (int i = 0; i < 4; i++) pop_check("t5_drain");
    check_all("t5_empty");

    // 6: reset mid-frame abandons it
    send_frame(8'h99, 1'b1, 0);
    model_frame(8'h99, 1'b1);
    check_all("t6_pre");
    fork
      send_frame(8'hFF, 1'b1, 0);
      begin
        idle(30);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        exp_q.delete();
        exp_overrun = 1'b0;
        exp_ferr    = 1'b0;
        check_all("t6_rst");
      end
    join
    check_all("t6_after");
    check("t6_state", 32'(dbg_state), 32'(IDLE));
    send_frame(8'h12, 1'b1, 0);
    model_frame(8'h12, 1'b1);
    check_all("t6_rx");
    pop_byte();

    // Randomised frames, stop bits, pops and clears
    for (int it = 0; it < 24; it++) begin
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 7) != 0);
      send_frame(b, ok, $urandom_range(0, 20));
      model_frame(b, ok);
      check_all("rnd_rx");
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) pop_check("rnd_pop");
      check_all("rnd_post");
      if ($urandom_range(0, 3) == 0) begin
        err_clear();
        check_all("rnd_clr");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive front-end that produces the core's 8-bit rxdata operand. Deserialises an 8N1 UART line, validates the start and stop bits, and buffers bytes in a first-word-fall-through FIFO. The core controller pops one byte per input instruction, and the datapath's register-write mux selects the head byte, zero-extended, as the write-back value.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 4.
FIFO_DEPTH, 16, byte entries; power of two, >= 2.

Ports:
clk  in  1  system clock, all logic rising-edge.
rst  in  1  reset, synchronous, active-high.
rxd  in  1  asynchronous serial line, idle high.
rx_pop  in  1  controller consumes the head byte this cycle.
rxdata  out  8  FIFO head byte; 8'h00 when empty.
rx_valid  out  1  FIFO non-empty.
rx_full  out  1  FIFO holds FIFO_DEPTH bytes.
overrun  out  1  sticky; a byte was dropped because the FIFO was full.
frame_err  out  1  sticky; stop bit sampled low.
err_clr  in  1  clears overrun and frame_err.

Behaviour:
- Reset:
  - rxdata=0, rx_valid=0, rx_full=0, overrun=0, frame_err=0.
  - FIFO pointers and count = 0; FSM=IDLE; bit counter and baud counter = 0; synchroniser flops = 1.
  - Reset asserted mid-frame abandons the frame; the partial byte is never pushed.
- Input path: rxd passes through a 2-flop synchroniser, giving rxs. All sampling uses rxs, so there are 2 cycles of input latency.
- FSM, with a baud counter bc:
  - IDLE: rxs==0 -> START, bc=0.
  - START: at bc==CLKS_PER_BIT/2-1, sample rxs (mid start bit).
    - rxs==1: false start (glitch) -> IDLE.
    - Else -> DATA, bc=0, bit index=0.
  - DATA: at bc==CLKS_PER_BIT-1, sample rxs into shift[idx] (LSB first) and set bc=0. After idx 7 -> STOP.
  - STOP: at bc==CLKS_PER_BIT-1, sample rxs.
    - rxs==1: push the byte -> IDLE.
    - rxs==0: set frame_err, discard the byte -> BRKWAIT.
  - BRKWAIT: stay until rxs==1, then -> IDLE. This prevents a break from retriggering frames.
- Push/pop:
  - A push occurs in the cycle after the stop-bit sample. rx_valid and rxdata reflect the byte on the following edge.
  - Push when count==FIFO_DEPTH and no pop in the same cycle: byte dropped, overrun set.
  - Push and pop in the same cycle on a full FIFO: both accepted, count unchanged.
  - Pop when empty: ignored, no state change.
  - Push and pop in the same cycle on an empty FIFO: push accepted and the pop ignored; count becomes 1.
  - Pointers are log2(FIFO_DEPTH) bits wide and wrap naturally. count is log2(FIFO_DEPTH)+1 bits wide.
  - rx_full = (count==FIFO_DEPTH); rx_valid = (count!=0).
- Sticky flags:
  - err_clr clears both flags on the next edge.
  - A set event in the same cycle as err_clr wins: the flag stays 1.
- rxdata is combinational from the head entry, gated to 0 when empty. It updates one cycle after a pop.

Decomposition:
- Package uart_pkg: typedef rx_state_t {IDLE, START, DATA, STOP, BRKWAIT}; localparam default CLKS_PER_BIT=868.
- Sub-module sync_fifo, parameters WIDTH=8 and DEPTH:
  - Inputs: push, pop, din.
  - Outputs: dout, empty, full, count, push_drop.
  - Handles the full/empty and simultaneous push/pop rules above.
- uart_rx_fifo holds the synchroniser, FSM and flags, and instantiates sync_fifo.

Test Plan:
All scenarios use CLKS_PER_BIT=8 and FIFO_DEPTH=4.
1. Single frame 0xA5 (LSB first, stop=1) -> rx_valid rises, rxdata=8'hA5; rx_pop one cycle -> rx_valid=0, rxdata=8'h00.
2. Low pulse of 2 cycles on idle rxd -> FSM returns to IDLE; no push, rx_valid stays 0.
3. Five frames 0x01..0x05 with no pops -> rx_full=1, head=0x01, overrun=1; popping four times returns 0x01..0x04, then empty.
4. Frame 0x3C with stop=0, rxd held low 40 cycles, then high, then frame 0x7E -> frame_err=1, 0x3C not stored; 0x7E received correctly; err_clr -> frame_err=0.
5. FIFO full and rx_pop in the same cycle as a 5th push -> count stays 4, overrun stays 0, new byte present at the tail.
6. rst asserted during DATA of frame 0xFF -> all outputs 0; the next clean frame 0x12 is received as 0x12.
